// File: rtl/flb_sdm_pkg.sv
// Shared types and constants for the FLB sigma-delta modulator and its decimator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package flb_sdm_pkg;

    // One decoded SDM sample, 0..3
    typedef logic [1:0] sdm_level_t;

    // Legal thermometer codes; anything else is a corrupted sample
    localparam logic [2:0] THRM_0 = 3'b000;
    localparam logic [2:0] THRM_1 = 3'b001;
    localparam logic [2:0] THRM_2 = 3'b011;
    localparam logic [2:0] THRM_3 = 3'b111;

    // Modulator output mean is SDM_OFFSET + x/256
    localparam int SDM_OFFSET = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACC    = 2'd2
    } dec_state_t;

    // Registered copy of the raw SDM input bundle
    typedef struct packed {
        logic       thrm_sel;
        logic [2:0] thrm;
        sdm_level_t bin;
    } sdm_sample_t;

    function automatic sdm_level_t thrm_popcount(input logic [2:0] code);
        return sdm_level_t'({1'b0, code[0]} + {1'b0, code[1]} + {1'b0, code[2]});
    endfunction

endpackage

// File: rtl/sdm_thrm_decode.sv
// Thermometer code to level decoder with illegal-code flag.
// Latency: combinational.
// Backpressure: none.
// Ports: thrm (3-bit code in), level (0..3 out), illegal (code not a thermometer).
module sdm_thrm_decode
    import flb_sdm_pkg::*;
(
    input  logic [2:0] thrm,
    output sdm_level_t level,
    output logic       illegal
);

    // Illegal codes still yield a usable level (their popcount) so a single
    // corrupted bit disturbs the window sum by at most one LSB.
    always_comb begin
        level   = thrm_popcount(thrm);
        illegal = 1'b1;
        case (thrm)
            THRM_0: begin level = 2'd0; illegal = 1'b0; end
            THRM_1: begin level = 2'd1; illegal = 1'b0; end
            THRM_2: begin level = 2'd2; illegal = 1'b0; end
            THRM_3: begin level = 2'd3; illegal = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdm_decimator.sv
// SDM stream decimator: integrates decoded levels over 2^WIN_LOG2 samples and recovers the 8-bit fractional word.
// Latency: dec_valid rises 2 edges after the edge capturing the last window sample into the input register.
// Backpressure: never stalls; an unread result is overwritten by the next one and dec_ovr is set.
// Ports: nsh_clk/nsh_rst_n; dec_en, thrm_sel, os_bin, os_thrm (stream in);
//        dec_data/dec_valid/dec_sat with dec_ready (result out); dec_ovr, thrm_err sticky, cleared by dec_ovr_clr.
module sdm_decimator
    import flb_sdm_pkg::*;
#(
    parameter int WIN_LOG2   = 8,   // legal 8..12
    parameter int SETTLE_CYC = 4    // legal 0..15
) (
    input  logic       nsh_clk,
    input  logic       nsh_rst_n,
    input  logic       dec_en,
    input  logic       thrm_sel,
    input  logic [1:0] os_bin,
    input  logic [2:0] os_thrm,
    input  logic       dec_ready,
    input  logic       dec_ovr_clr,
    output logic [7:0] dec_data,
    output logic       dec_valid,
    output logic       dec_sat,
    output logic       dec_ovr,
    output logic       thrm_err
);

    localparam int CW    = WIN_LOG2;        // sample / settle counter
    localparam int AW    = WIN_LOG2 + 2;    // accumulator, holds up to 3N
    localparam int RW    = WIN_LOG2 + 3;    // signed window result
    localparam int SHIFT = WIN_LOG2 - 8;

    localparam logic [CW-1:0]        SETTLE_LAST = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic signed [RW-1:0] WIN_OFFSET  = RW'(SDM_OFFSET * (1 << WIN_LOG2));

    // ------------------------------------------------------------------
    // Input register: all decoding works on these copies
    // ------------------------------------------------------------------
    sdm_sample_t in_q;

    always_ff @(posedge nsh_clk or negedge nsh_rst_n) begin
        if (!nsh_rst_n) begin
            in_q <= '0;
        end else begin
            in_q <= '{thrm_sel: thrm_sel, thrm: os_thrm, bin: os_bin};
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    sdm_level_t thrm_level;
    logic       thrm_illegal;
    sdm_level_t level;

    sdm_thrm_decode u_thrm_decode (
        .thrm    (in_q.thrm),
        .level   (thrm_level),
        .illegal (thrm_illegal)
    );

    assign level = in_q.thrm_sel ? thrm_level : in_q.bin;

    // ------------------------------------------------------------------
    // Window FSM and accumulator
    // ------------------------------------------------------------------
    dec_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [AW-1:0]        sum;
    logic signed [RW-1:0] result;
    logic                 win_done;

    // The closing sample is folded in combinationally so the next window
    // starts on the very next sample with no gap.
    assign sum    = acc_q + AW'(level);
    assign result = $signed({1'b0, sum}) - WIN_OFFSET;

    always_ff @(posedge nsh_clk or negedge nsh_rst_n) begin
        if (!nsh_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        win_done = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                acc_d = '0;
                if (dec_en) begin
                    state_d = (SETTLE_CYC == 0) ? ACC : SETTLE;
                end
            end
            SETTLE: begin
                // Samples here are still polluted by the modulator pipeline
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ACC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACC: begin
                if (&cnt_q) begin
                    win_done = 1'b1;
                    cnt_d    = '0;
                    acc_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    acc_d = sum;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                acc_d   = '0;
            end
        endcase

        // Disable wins over everything, including a window closing this cycle
        if (!dec_en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            acc_d    = '0;
            win_done = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Result pipeline stage, then scale and clamp
    // ------------------------------------------------------------------
    logic                 win_vld_q;
    logic signed [RW-1:0] win_res_q;
    logic signed [RW-1:0] scaled;
    logic                 clamp_lo;
    logic                 clamp_hi;
    logic [7:0]           sat_data;

    always_ff @(posedge nsh_clk or negedge nsh_rst_n) begin
        if (!nsh_rst_n) begin
            win_vld_q <= 1'b0;
            win_res_q <= '0;
        end else begin
            win_vld_q <= win_done;
            if (win_done) begin
                win_res_q <= result;
            end
        end
    end

    assign scaled   = win_res_q >>> SHIFT;
    assign clamp_lo = scaled[RW-1];
    assign clamp_hi = !scaled[RW-1] && (scaled[RW-2:8] != '0);
    assign sat_data = clamp_lo ? 8'h00 : (clamp_hi ? 8'hFF : scaled[7:0]);

    // ------------------------------------------------------------------
    // Output register, handshake and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge nsh_clk or negedge nsh_rst_n) begin
        if (!nsh_rst_n) begin
            dec_data  <= '0;
            dec_valid <= 1'b0;
            dec_sat   <= 1'b0;
        end else if (win_vld_q) begin
            // A handshake on this same edge is simply absorbed by the reload
            dec_data  <= sat_data;
            dec_sat   <= clamp_lo | clamp_hi;
            dec_valid <= 1'b1;
        end else if (dec_valid && dec_ready) begin
            dec_valid <= 1'b0;
        end
    end

    always_ff @(posedge nsh_clk or negedge nsh_rst_n) begin
        if (!nsh_rst_n) begin
            dec_ovr  <= 1'b0;
            thrm_err <= 1'b0;
        end else begin
            if (win_vld_q && dec_valid && !dec_ready) begin
                dec_ovr <= 1'b1;
            end else if (dec_ovr_clr) begin
                dec_ovr <= 1'b0;
            end

            if (in_q.thrm_sel && thrm_illegal && (state_q != IDLE)) begin
                thrm_err <= 1'b1;
            end else if (dec_ovr_clr) begin
                thrm_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdm_decimator.sv
module tb_sdm_decimator;

    logic       nsh_clk = 1'b0;
    logic       nsh_rst_n;
    logic       dec_en;
    logic       thrm_sel;
    logic [1:0] os_bin;
    logic [2:0] os_thrm;
    logic       dec_ready;
    logic       dec_ovr_clr;
    logic [7:0] dec_data;
    logic       dec_valid;
    logic       dec_sat;
    logic       dec_ovr;
    logic       thrm_err;

    always #5 nsh_clk = ~nsh_clk;

    sdm_decimator #(.WIN_LOG2(8), .SETTLE_CYC(4)) dut (
        .nsh_clk     (nsh_clk),
        .nsh_rst_n   (nsh_rst_n),
        .dec_en      (dec_en),
        .thrm_sel    (thrm_sel),
        .os_bin      (os_bin),
        .os_thrm     (os_thrm),
        .dec_ready   (dec_ready),
        .dec_ovr_clr (dec_ovr_clr),
        .dec_data    (dec_data),
        .dec_valid   (dec_valid),
        .dec_sat     (dec_sat),
        .dec_ovr     (dec_ovr),
        .thrm_err    (thrm_err)
    );

    localparam int M_MAN   = 0;  // bench drives os_* by hand
    localparam int M_CONST = 1;  // constant level cval
    localparam int M_ALT   = 2;  // 1,2,1,2,...
    localparam int M_SDM1  = 3;  // 1st-order modulator model, input xval
    localparam int M_SDM2  = 4;  // MASH 1-1 modulator model, input xval

    int         checks = 0;
    int         errors = 0;
    int         ecnt;
    int         mode;
    int         cval;
    int         xval;
    logic       alt;
    logic [7:0] a1, a2;
    logic       c2p;

    typedef struct {
        string name;
        int    m;
        int    c;
        int    x;
        logic  tsel;
        int    lo;
        int    hi;
        int    sat;
    } vec_t;

    vec_t vt[8];

    function automatic logic [2:0] thermo(input int l);
        case (l)
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Next stream sample, written just after an active edge
    task automatic gen_next();
        int         lvl;
        logic [8:0] s1, s2;
        lvl = -1;
        case (mode)
            M_CONST: lvl = cval;
            M_ALT: begin
                alt = ~alt;
                lvl = alt ? 2 : 1;
            end
            M_SDM1: begin
                s1  = {1'b0, a1} + 9'(xval);
                a1  = s1[7:0];
                lvl = 1 + int'(s1[8]);
            end
            M_SDM2: begin
                s1  = {1'b0, a1} + 9'(xval);
                a1  = s1[7:0];
                s2  = {1'b0, a2} + {1'b0, a1};
                a2  = s2[7:0];
                lvl = 1 + int'(s1[8]) + int'(s2[8]) - int'(c2p);
                c2p = s2[8];
            end
            default: lvl = -1;
        endcase
        if (lvl >= 0) begin
            os_bin  = 2'(lvl);
            os_thrm = thermo(lvl);
        end
    endtask

    task automatic tick();
        @(posedge nsh_clk);
        #1;
        ecnt++;
        gen_next();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input logic [31:0] act, input int lo, input int hi);
        checks++;
        if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Tick until dec_valid is seen or the budget runs out; waited reports edges
    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!dec_valid && waited < budget);
    endtask

    // Return to IDLE, switch stream source, flush, then enable at ecnt=0
    task automatic start(input int m, input int c, input int x, input logic tsel);
        dec_en   = 1'b0;
        mode     = m;
        cval     = c;
        xval     = x;
        thrm_sel = tsel;
        a1 = '0; a2 = '0; c2p = 1'b0; alt = 1'b0;
        repeat (3) tick();
        ecnt   = 0;
        dec_en = 1'b1;
    endtask

    initial begin
        int   n;
        logic seen;

        nsh_rst_n   = 1'b0;
        dec_en      = 1'b0;
        thrm_sel    = 1'b0;
        os_bin      = 2'd0;
        os_thrm     = 3'b000;
        dec_ready   = 1'b1;
        dec_ovr_clr = 1'b0;
        mode        = M_MAN;
        cval = 0; xval = 0; alt = 1'b0; a1 = '0; a2 = '0; c2p = 1'b0; ecnt = 0;

        vt[0] = '{"bin_hold1",  M_CONST, 1, 0,    1'b0, 8'h00, 8'h00, 0};
        vt[1] = '{"bin_alt12",  M_ALT,   0, 0,    1'b0, 8'h80, 8'h80, 0};
        vt[2] = '{"bin_hold2",  M_CONST, 2, 0,    1'b0, 8'hFF, 8'hFF, 1};
        vt[3] = '{"bin_hold0",  M_CONST, 0, 0,    1'b0, 8'h00, 8'h00, 1};
        vt[4] = '{"sdm1_x40",   M_SDM1,  0, 8'h40, 1'b1, 8'h40, 8'h40, 0};
        vt[5] = '{"sdm2_x40",   M_SDM2,  0, 8'h40, 1'b1, 8'h3F, 8'h41, 0};
        vt[6] = '{"sdm1_xc3",   M_SDM1,  0, 8'hC3, 1'b1, 8'hC3, 8'hC3, 0};
        vt[7] = '{"thrm_hold1", M_CONST, 1, 0,    1'b1, 8'h00, 8'h00, 0};

        // Reset state
        repeat (2) tick();
        chk("rst_data",  dec_data,  0);
        chk("rst_valid", dec_valid, 0);
        chk("rst_sat",   dec_sat,   0);
        chk("rst_ovr",   dec_ovr,   0);
        chk("rst_terr",  thrm_err,  0);
        nsh_rst_n = 1'b1;
        tick();

        // Table-driven streams, consumer always ready
        foreach (vt[i]) begin
            start(vt[i].m, vt[i].c, vt[i].x, vt[i].tsel);
            wait_valid(400, n);
            chk({vt[i].name, "_latency"}, n, 262);
            chk_rng({vt[i].name, "_data1"}, dec_data, vt[i].lo, vt[i].hi);
            chk({vt[i].name, "_sat1"}, dec_sat, vt[i].sat);
            wait_valid(300, n);
            chk({vt[i].name, "_period"}, n, 256);
            chk_rng({vt[i].name, "_data2"}, dec_data, vt[i].lo, vt[i].hi);
            chk({vt[i].name, "_terr"}, thrm_err, 0);
        end

        // Overrun: second result replaces the unread first, then clear, then async reset
        start(M_CONST, 1, 0, 1'b0);
        dec_ready = 1'b0;
        wait_valid(400, n);
        chk("ovr_first_lat", n, 262);
        chk("ovr_first_data", dec_data, 8'h00);
        cval    = 2;
        os_bin  = 2'd2;
        os_thrm = 3'b011;
        // window 2 holds two level-1 samples then 254 level-2 samples: 510-256 = 254
        repeat (256) tick();
        chk("ovr_valid", dec_valid, 1);
        chk("ovr_data", dec_data, 8'hFE);
        chk("ovr_sat", dec_sat, 0);
        chk("ovr_flag", dec_ovr, 1);
        dec_ovr_clr = 1'b1;
        tick();
        dec_ovr_clr = 1'b0;
        chk("ovr_clr", dec_ovr, 0);
        chk("ovr_clr_hold", dec_valid, 1);
        dec_ready = 1'b1;
        tick();
        chk("ovr_consumed", dec_valid, 0);
        dec_ready = 1'b0;
        wait_valid(300, n);
        chk("ovr_next_gap", n, 254);
        chk("ovr_next_sat", dec_sat, 1);
        #2 nsh_rst_n = 1'b0;
        #1;
        chk("arst_data",  dec_data,  0);
        chk("arst_valid", dec_valid, 0);
        chk("arst_sat",   dec_sat,   0);
        tick();
        nsh_rst_n = 1'b1;
        tick();

        // Handshake on the same edge as a new result: no overrun
        start(M_CONST, 2, 0, 1'b0);
        dec_ready = 1'b0;
        wait_valid(400, n);
        chk("hs_lat", n, 262);
        repeat (255) tick();
        chk("hs_held", dec_valid, 1);
        dec_ready = 1'b1;
        tick();
        chk("hs_valid", dec_valid, 1);
        chk("hs_ovr", dec_ovr, 0);
        chk("hs_data", dec_data, 8'hFF);
        tick();
        chk("hs_drop", dec_valid, 0);

        // Illegal thermometer code counted as its popcount
        os_bin  = 2'd1;
        os_thrm = 3'b001;
        start(M_MAN, 0, 0, 1'b1);
        while (ecnt < 100) tick();
        chk("terr_before", thrm_err, 0);
        os_thrm = 3'b101;
        tick();
        os_thrm = 3'b001;
        repeat (9) tick();
        chk("terr_set", thrm_err, 1);
        wait_valid(300, n);
        chk("terr_lat", ecnt, 262);
        chk("terr_data", dec_data, 8'h01);
        dec_ovr_clr = 1'b1;
        thrm_sel    = 1'b0;
        tick();
        dec_ovr_clr = 1'b0;
        chk("terr_clr", thrm_err, 0);
        while (ecnt < 300) tick();
        os_thrm = 3'b101;
        tick();
        os_thrm = 3'b001;
        wait_valid(300, n);
        chk("terr_bin_lat", ecnt, 518);
        chk("terr_bin_data", dec_data, 8'h00);
        chk("terr_bin_flag", thrm_err, 0);

        // Disable mid-window: partial window dropped, settle re-run
        start(M_ALT, 0, 0, 1'b0);
        repeat (105) tick();
        dec_en = 1'b0;
        seen   = 1'b0;
        repeat (10) begin
            tick();
            if (dec_valid) seen = 1'b1;
        end
        chk("dis_no_result", seen, 0);
        ecnt   = 0;
        dec_en = 1'b1;
        wait_valid(400, n);
        chk("dis_relat", n, 262);
        chk("dis_data", dec_data, 8'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
